// File: rtl/pwm_capture.sv
// Purpose   : PWM period / high-width capture with servo range check and stuck-input detection.
// Latency   : valid rises 3 clk_div edges after s1 first samples the new rising edge (s1, s2, output register).
// Backpress.: none; valid is a one-cycle strobe, and results hold until the next strobe.
//
// Ports:
//    clk_div     block clock, all state on its rising edge
//    rst         asynchronous active-high reset
//    pwm_in      asynchronous PWM input
//    high_width  high-phase length of the last complete period (clk_div cycles)
//    period      total length of the last complete period (clk_div cycles)
//    valid       one-cycle strobe marking a new high_width/period/in_range
//    in_range    MIN_HIGH <= high_width <= MAX_HIGH for the current result
//    stuck_high  input held high longer than TIMEOUT; cleared by the next valid
//    stuck_low   input held low longer than TIMEOUT; cleared by the next valid
module pwm_capture #(
   parameter int unsigned CW       = 32,
   parameter int unsigned MIN_HIGH = 50_000,
   parameter int unsigned MAX_HIGH = 100_000,
   parameter int unsigned TIMEOUT  = 2_000_000
) (
   input  logic          clk_div,
   input  logic          rst,
   input  logic          pwm_in,
   output logic [CW-1:0] high_width,
   output logic [CW-1:0] period,
   output logic          valid,
   output logic          in_range,
   output logic          stuck_high,
   output logic          stuck_low
);

   localparam logic [CW-1:0] MIN_C     = CW'(MIN_HIGH);
   localparam logic [CW-1:0] MAX_C     = CW'(MAX_HIGH);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

   logic          s1;
   logic          s2;
   logic          s3;
   logic          rise;
   logic          fall;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] hi_lat;
   logic          hi_ok;

   // Three-flop chain; s1/s2 resolve metastability, s3 is the previous
   // synchronized sample for edge detection. Resetting to 1 means an input
   // that is already high at reset release never looks like a fresh rise,
   // so the first measured period always starts on a genuine edge.
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= pwm_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise  = s2 & ~s3;
   assign fall  = ~s2 & s3;
   assign hi_ok = (hi_lat >= MIN_C) && (hi_lat <= MAX_C);

   // cnt counts the current phase starting at 1 in the cycle after its edge
   // was detected, so on the closing edge it equals the phase length exactly.
   // Edges are tested before the timeout compare: a phase of exactly TIMEOUT
   // cycles is still a valid measurement.
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         hi_lat     <= '0;
         high_width <= '0;
         period     <= '0;
         valid      <= 1'b0;
         in_range   <= 1'b0;
         stuck_high <= 1'b0;
         stuck_low  <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Falls are ignored here; only a rise can start a period.
               if (rise) begin
                  cnt   <= CW'(1);
                  state <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (fall) begin
                  hi_lat <= cnt;
                  cnt    <= CW'(1);
                  state  <= ST_LOW;
               end else if (cnt == TIMEOUT_C) begin
                  stuck_high <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_LOW: begin
               if (rise) begin
                  // This rise closes one period and opens the next.
                  high_width <= hi_lat;
                  period     <= hi_lat + cnt;
                  in_range   <= hi_ok;
                  valid      <= 1'b1;
                  stuck_high <= 1'b0;
                  stuck_low  <= 1'b0;
                  cnt        <= CW'(1);
                  state      <= ST_HIGH;
               end else if (cnt == TIMEOUT_C) begin
                  stuck_low <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

   localparam int T  = 1000;
   localparam int LO = 50;
   localparam int HI = 100;

   logic        clk_div = 1'b0;
   logic        rst;
   logic        pwm_in;
   logic [31:0] high_width;
   logic [31:0] period;
   logic        valid;
   logic        in_range;
   logic        stuck_high;
   logic        stuck_low;

   pwm_capture #(.CW(32), .MIN_HIGH(LO), .MAX_HIGH(HI), .TIMEOUT(T)) dut (
      .clk_div    (clk_div),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .high_width (high_width),
      .period     (period),
      .valid      (valid),
      .in_range   (in_range),
      .stuck_high (stuck_high),
      .stuck_low  (stuck_low)
   );

   always #5 clk_div = ~clk_div;

   typedef struct {
      longint hw;
      longint per;
      longint ir;
      longint cyc;
   } exp_t;

   exp_t   sb[$];
   int     n_chk  = 0;
   int     n_fail = 0;
   longint cyc    = 0;
   logic   prev_valid = 1'b0;

   // bench model of what the block should be doing
   bit     armed = 0;
   int     prev_h = 0;
   int     prev_l = 0;
   longint last_hw = 0;
   longint last_per = 0;
   longint last_ir = 0;
   bit     m_sh = 0;
   bit     m_sl = 0;

   always @(posedge clk_div) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk_div) begin
      if (valid === 1'b1) begin
         check("valid_one_cycle", prev_valid, 0);
         if (sb.size() == 0) begin
            check("unexpected_valid_queue_depth", sb.size(), 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("high_width", high_width, e.hw);
            check("period", period, e.per);
            check("in_range", in_range, e.ir);
            check("valid_cycle", cyc, e.cyc);
            check("stuck_high_at_valid", stuck_high, 0);
            check("stuck_low_at_valid", stuck_low, 0);
         end
      end
      prev_valid = valid;
   end

   task automatic tick();
      @(posedge clk_div);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_high_width"}, high_width, 0);
      check({tag, "_period"}, period, 0);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_in_range"}, in_range, 0);
      check({tag, "_stuck_high"}, stuck_high, 0);
      check({tag, "_stuck_low"}, stuck_low, 0);
   endtask

   task automatic model_reset();
      armed = 0;
      last_hw = 0;
      last_per = 0;
      last_ir = 0;
      m_sh = 0;
      m_sl = 0;
   endtask

   // Drive a rising edge; if a full high+low has been seen since measuring
   // began, that period is reported 3 edges later.
   task automatic do_rise();
      exp_t e;
      if (armed) begin
         e.hw  = prev_h;
         e.per = prev_h + prev_l;
         e.ir  = (prev_h >= LO && prev_h <= HI) ? 1 : 0;
         e.cyc = cyc + 3;
         sb.push_back(e);
         last_hw  = e.hw;
         last_per = e.per;
         last_ir  = e.ir;
         m_sh = 0;
         m_sl = 0;
      end
      pwm_in = 1'b1;
   endtask

   task automatic held_check(input string tag);
      check({tag, "_held_high_width"}, high_width, last_hw);
      check({tag, "_held_period"}, period, last_per);
      check({tag, "_held_in_range"}, in_range, last_ir);
   endtask

   task automatic pulse(input int h, input int l);
      do_rise();
      for (int i = 1; i <= h; i++) begin
         tick();
         if (h > T && i == T + 2) check("stuck_high_not_yet", stuck_high, 0);
         if (h > T && i == T + 3) begin
            check("stuck_high_set", stuck_high, 1);
            held_check("stuck_high");
         end
      end
      pwm_in = 1'b0;
      for (int j = 1; j <= l; j++) begin
         tick();
         if (h <= T && l > T && j == T + 2) check("stuck_low_not_yet", stuck_low, 0);
         if (h <= T && l > T && j == T + 3) begin
            check("stuck_low_set", stuck_low, 1);
            held_check("stuck_low");
         end
      end
      if (h > T) begin
         armed = 0;
         m_sh  = 1;
      end else if (l > T) begin
         armed = 0;
         m_sl  = 1;
      end else begin
         armed = 1;
      end
      prev_h = h;
      prev_l = l;
      if (h + l >= 4) begin
         check("stuck_high_level", stuck_high, m_sh);
         check("stuck_low_level", stuck_low, m_sl);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, scoreboard depth %0d", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with input low
      rst = 1'b1;
      pwm_in = 1'b0;
      model_reset();
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;
      repeat (5) tick();

      // 1: nominal 75/925
      repeat (5) pulse(75, 925);

      // 2: out-of-range and boundary high widths
      repeat (2) pulse(40, 960);
      repeat (2) pulse(101, 899);
      repeat (2) pulse(100, 900);
      repeat (2) pulse(50, 950);

      // 3: stuck high, recover, stuck low, recover
      pulse(75, 925);
      pulse(1500, 925);
      repeat (3) pulse(75, 925);
      pulse(75, 1500);
      repeat (3) pulse(75, 925);

      // 4: input high through reset release
      pwm_in = 1'b1;
      rst = 1'b1;
      model_reset();
      repeat (3) tick();
      check_zero("reset_high");
      rst = 1'b0;
      repeat (10) tick();
      pwm_in = 1'b0;
      repeat (500) tick();
      repeat (3) pulse(75, 925);

      // 5: reset in the middle of a high phase
      do_rise();
      repeat (20) tick();
      rst = 1'b1;
      #1;
      check_zero("reset_mid_high");
      model_reset();
      repeat (2) tick();
      rst = 1'b0;
      repeat (30) tick();
      pwm_in = 1'b0;
      repeat (400) tick();
      repeat (3) pulse(75, 925);

      // 6: fastest input, then phases of exactly TIMEOUT
      repeat (8) pulse(1, 1);
      pulse(1000, 925);
      pulse(75, 1000);
      repeat (2) pulse(75, 925);

      repeat (10) tick();
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
